// File: rtl/fetch_npc.sv
// ----------------------------------------------------------------------------
// fetch_npc
//   Instruction-fetch stage wrapped around an external PC register. It
//   computes the next PC, issues instruction-memory reads at the current PC
//   with a req/ack handshake, and queues fetched {pc, instr} pairs in a small
//   FIFO that decode drains with a valid/ready handshake. Stalls hold the PC
//   (npc = pc), and branch/jump redirects or exceptions flush the queue and
//   steer the PC to the new target.
//
// Parameters
//   EXC_VECTOR  exception entry address (bits [1:0] must be zero)
//   QDEPTH      fetch FIFO depth (power of two, >= 2)
//
// Ports
//   clk              in   rising-edge clock
//   Reset            in   asynchronous, active-low reset
//   pc               in   current PC from the PC register
//   npc              out  next PC to the PC register (combinational)
//   imem_req         out  instruction read request (level)
//   imem_addr        out  read address (always equal to pc)
//   imem_ack         in   one-cycle pulse, imem_rdata valid
//   imem_rdata       in   instruction word
//   redirect_valid   in   one-cycle pulse, branch/jump taken
//   redirect_target  in   redirect address
//   exc_valid        in   one-cycle pulse, take exception
//   id_valid         out  FIFO head valid toward decode
//   id_instr         out  head instruction
//   id_pc            out  PC of the head instruction
//   id_ready         in   decode accepts the head entry
// ----------------------------------------------------------------------------
module fetch_npc #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pend_tgt;
    logic          w_pend_load;

    logic [31:0]   r_q_pc    [QDEPTH];
    logic [31:0]   r_q_instr [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    logic          w_flush;
    logic [31:0]   w_tgt;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_npc;

    // Exception outranks a simultaneous redirect; redirect targets are
    // word-aligned by forcing the low two bits to zero.
    assign w_flush = exc_valid | redirect_valid;
    assign w_tgt   = exc_valid ? EXC_VECTOR : {redirect_target[31:2], 2'b00};

    assign imem_req  = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign imem_addr = pc;

    // A flush hides the head immediately so decode never consumes a word
    // from the path being abandoned.
    assign id_valid = (r_count != '0) && !w_flush;
    assign id_instr = r_q_instr[r_rd_ptr];
    assign id_pc    = r_q_pc[r_rd_ptr];

    assign w_pop  = id_valid && id_ready;
    assign w_push = (r_state == S_WAIT) && imem_ack && !w_flush;

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + {{(CW-1){1'b0}}, w_push}
                                   - {{(CW-1){1'b0}}, w_pop};
        end
    end

    // Next-state / next-PC. The PC only moves when no read is outstanding
    // (or the outstanding read completes this cycle), keeping imem_addr
    // stable across the handshake.
    always_comb begin
        w_state_next = r_state;
        w_npc        = pc;
        w_pend_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_WAIT;
                if (w_flush) begin
                    w_npc = w_tgt;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (w_flush) begin
                        w_npc = w_tgt;
                    end else begin
                        w_npc = pc + 32'd4;
                        if (w_count_next == QD) begin
                            w_state_next = S_FULL;
                        end
                    end
                end else if (w_flush) begin
                    // Read still in flight: remember where to go and discard
                    // the response when it eventually arrives.
                    w_pend_load  = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_npc        = w_flush ? w_tgt : r_pend_tgt;
                    w_state_next = S_WAIT;
                end else if (w_flush) begin
                    w_pend_load = 1'b1;
                end
            end
            S_FULL: begin
                if (w_flush) begin
                    w_npc        = w_tgt;
                    w_state_next = S_WAIT;
                end else if (w_pop) begin
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign npc = w_npc;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_pend_tgt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_pend_load) begin
                r_pend_tgt <= w_tgt;
            end
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // Queue storage carries data only; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!Reset) !(w_push && (r_count == QD))
    );

    a_addr_stable: assert property (
        @(posedge clk) disable iff (!Reset)
        (imem_req && !imem_ack) |=> $stable(imem_addr)
    );

endmodule

// File: tb/tb_fetch_npc.sv
// ----------------------------------------------------------------------------
// tb_fetch_npc
//   Directed bench for fetch_npc. The bench owns the PC register (pc <= npc)
//   and plays instruction memory and decode by driving ack/rdata/ready at the
//   falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_fetch_npc;

    logic        clk;
    logic        Reset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    fetch_npc #(
        .EXC_VECTOR (32'h0000_4180),
        .QDEPTH     (2)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .pc              (pc),
        .npc             (npc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_ready        (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) pc <= 32'h0;
        else        pc <= npc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        exc_valid       = 1'b0;
        id_ready        = 1'b0;
    endtask

    // Leaves the bench at a falling edge with the DUT in IDLE and pc = 0.
    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%0h want=0", id_valid); end
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL rst_npc got=%h want=00000000", npc); end
        @(negedge clk);
        Reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%0h want=0", imem_req); end
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h want=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h want=00000000", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0000;
        #1;
        total++; if (npc !== 32'h4) begin bad++; $display("FAIL stream_npc0 got=%h want=00000004", npc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got=%0h want=0", id_valid); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = 32'hA000_0000 | imem_addr;
            #1;
            exp_pc = 32'(4 * j);
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0h want=1", j, id_valid); end
            total++; if (id_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", j, id_pc, exp_pc); end
            total++; if (id_instr !== (32'hA000_0000 | exp_pc)) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", j, id_instr, 32'hA000_0000 | exp_pc); end
            total++; if (imem_addr !== exp_pc + 32'h4) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", j, imem_addr, exp_pc + 32'h4); end
        end
        imem_ack = 1'b0;
    endtask

    task automatic fill_to_full();
        do_reset();
        id_ready = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hB000_0000;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hB000_0004;
        @(negedge clk);
        imem_ack   = 1'b0;
        #1;
    endtask

    task automatic test_full();
        fill_to_full();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%0h want=0", imem_req); end
        total++; if (npc !== 32'h8) begin bad++; $display("FAIL full_npc got=%h want=00000008", npc); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL full_pc got=%h want=00000008", imem_addr); end
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%0h/%h want=1/00000000", id_valid, id_pc); end
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_hold_req got=%0h want=0", imem_req); end
        total++; if (npc !== 32'h8) begin bad++; $display("FAIL full_hold_npc got=%h want=00000008", npc); end
        id_ready = 1'b1;
        #1;
        total++; if (id_instr !== 32'hB000_0000) begin bad++; $display("FAIL full_instr got=%h want=b0000000", id_instr); end
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL resume_req got=%0h want=1", imem_req); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL resume_addr got=%h want=00000008", imem_addr); end
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin bad++; $display("FAIL resume_head got=%0h/%h want=1/00000004", id_valid, id_pc); end
    endtask

    task automatic test_drain();
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        #1;
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL drain_npc0 got=%h want=00000000", npc); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL drain_hold got=%0h/%h want=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (npc !== 32'h40) begin bad++; $display("FAIL drain_npc got=%h want=00000040", npc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL drain_valid0 got=%0h want=0", id_valid); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL drain_stale got=%0h want=0", id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL drain_next got=%0h/%h want=1/00000040", imem_req, imem_addr); end
    endtask

    task automatic test_exc_priority();
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC000_0000;
        @(negedge clk);
        imem_ack        = 1'b1;
        imem_rdata      = 32'hC000_0004;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        exc_valid       = 1'b1;
        #1;
        total++; if (npc !== 32'h0000_4180) begin bad++; $display("FAIL exc_npc got=%h want=00004180", npc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL exc_valid_hidden got=%0h want=0", id_valid); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL exc_flushed got=%0h want=0", id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4180) begin bad++; $display("FAIL exc_fetch got=%0h/%h want=1/00004180", imem_req, imem_addr); end
    endtask

    task automatic test_full_redirect();
        fill_to_full();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        #1;
        total++; if (npc !== 32'h40) begin bad++; $display("FAIL fullredir_npc got=%h want=00000040", npc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fullredir_valid got=%0h want=0", id_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fullredir_empty got=%0h want=0", id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL fullredir_wait got=%0h/%h want=1/00000040", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        imem_ack        = 1'b1;
        imem_rdata      = 32'h0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        #1;
        total++; if (npc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_tgt got=%h want=fffffffc", npc); end
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h1234_5678;
        #1;
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h want=00000000", npc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL wrap_nopush got=%0h want=0", id_valid); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_head got=%0h/%h want=1/fffffffc", id_valid, id_pc); end
        total++; if (id_instr !== 32'h1234_5678) begin bad++; $display("FAIL wrap_instr got=%h want=12345678", id_instr); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hE000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (id_valid !== 1'b1 || imem_req !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0h/%0h want=1/1", id_valid, imem_req); end
        #1;
        Reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%0h want=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0h want=0", id_valid); end
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL midrst_npc got=%h want=00000000", npc); end
        @(negedge clk);
        Reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0h want=0", imem_req); end
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_restart got=%0h/%h want=1/00000000", imem_req, imem_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL midrst_empty got=%0h want=0", id_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_exc_priority();
        test_full_redirect();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
